// File: rtl/interconnect_pkg.sv
// Shared types and helpers for the cache-refill AXI read/write arbiters.
package interconnect_pkg;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_idx_e;

  typedef enum logic {
    IDLE    = 1'b0,
    AR_SEND = 1'b1
  } arb_state_e;

  localparam int CACHE_LINE_BEATS = 4;

  // Requester index occupies ARID[0]; the remaining bits come from the ID base.
  function automatic logic [31:0] arid_encode(input logic [31:0] id_base, input req_idx_e idx);
    return {id_base[31:1], idx};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: rr_i names the favoured requester on a tie.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       rr_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       rr_next_o
);

  always_comb begin
    gnt_o     = 2'b00;
    rr_next_o = rr_i;
    if (en_i) begin
      if (&req_i) gnt_o = rr_i ? 2'b10 : 2'b01;
      else        gnt_o = req_i;
      if (|gnt_o) rr_next_o = ~gnt_o[1];
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 AR/R channel between the icache and dcache refill ports,
// tagging each burst with a per-requester ARID and steering R beats by RID.
module axi_rd_arbiter
  import interconnect_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int BURST_LEN      = CACHE_LINE_BEATS - 1,
  parameter int ID_BASE        = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [1:0]                  req_valid_i,
  input  logic [2*AXI_ADDR_WIDTH-1:0] req_addr_i,
  output logic [1:0]                  req_ready_o,
  output logic [1:0]                  rsp_valid_o,
  input  logic [1:0]                  rsp_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_data_o,
  output logic                        rsp_last_o,
  output logic                        rsp_err_o,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_o,
  output logic [AXI_ID_WIDTH-1:0]     axi_ar_id_o,
  output logic [7:0]                  axi_ar_len_o,
  output logic                        axi_ar_valid_o,
  input  logic                        axi_ar_ready_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_r_id_i,
  input  logic [1:0]                  axi_r_resp_i,
  input  logic                        axi_r_last_i,
  input  logic                        axi_r_valid_i,
  output logic                        axi_r_ready_o,
  output logic                        stray_r_o
);

  localparam logic [AXI_ID_WIDTH-1:0] ID_BASE_W = AXI_ID_WIDTH'(ID_BASE);

  arb_state_e                 state_q;
  logic                       rr_q;
  logic [1:0]                 busy_q;
  logic [AXI_ADDR_WIDTH-1:0]  ar_addr_q;
  logic [AXI_ID_WIDTH-1:0]    ar_id_q;
  logic                       ar_valid_q;

  logic [1:0]                 eligible;
  logic [1:0]                 gnt;
  logic                       rr_next;
  logic [AXI_ADDR_WIDTH-1:0]  gnt_addr;
  logic [AXI_ID_WIDTH-1:0]    gnt_id;

  logic                       r_idx;
  logic                       r_id_match;
  logic                       r_owned;
  logic [1:0]                 r_done;
  logic                       unused_resp_okay;

  assign eligible = req_valid_i & ~busy_q;

  rr_arb2 u_rr_arb2 (
    .req_i     (eligible),
    .rr_i      (rr_q),
    .en_i      (state_q == IDLE),
    .gnt_o     (gnt),
    .rr_next_o (rr_next)
  );

  assign req_ready_o = gnt;
  assign gnt_addr    = gnt[1] ? req_addr_i[AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]
                              : req_addr_i[0 +: AXI_ADDR_WIDTH];
  assign gnt_id      = AXI_ID_WIDTH'(arid_encode(32'(ID_BASE), req_idx_e'(gnt[1])));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_valid_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (|gnt) begin
        state_q    <= AR_SEND;
        rr_q       <= rr_next;
        ar_addr_q  <= gnt_addr;
        ar_id_q    <= gnt_id;
        ar_valid_q <= 1'b1;
      end
    end else if (axi_ar_ready_i) begin
      state_q    <= IDLE;
      ar_valid_q <= 1'b0;
    end
  end

  assign axi_ar_addr_o  = ar_addr_q;
  assign axi_ar_id_o    = ar_id_q;
  assign axi_ar_len_o   = 8'(BURST_LEN);
  assign axi_ar_valid_o = ar_valid_q;

  // R path: a beat belongs to a requester only if the ID base matches and its burst is open.
  assign r_idx      = axi_r_id_i[0];
  assign r_id_match = (axi_r_id_i >> 1) == (ID_BASE_W >> 1);
  assign r_owned    = r_id_match && busy_q[r_idx];

  assign rsp_valid_o   = (r_owned && axi_r_valid_i) ? (2'b01 << r_idx) : 2'b00;
  assign rsp_data_o    = axi_r_data_i;
  assign rsp_last_o    = axi_r_last_i;
  assign rsp_err_o     = axi_r_resp_i[1];
  // Unowned beats are sunk so a confused crossbar cannot stall the channel; quiet while in reset.
  assign axi_r_ready_o = rst_ni && (r_owned ? rsp_ready_i[r_idx] : 1'b1);
  assign stray_r_o     = rst_ni && axi_r_valid_i && !r_owned;

  assign r_done = (r_owned && axi_r_valid_i && axi_r_ready_o && axi_r_last_i)
                  ? (2'b01 << r_idx) : 2'b00;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= 2'b00;
    else         busy_q <= (busy_q | gnt) & ~r_done;
  end

  assign unused_resp_okay = axi_r_resp_i[0];

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: routing vector table plus AR/R sequences.
module tb_axi_rd_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_valid_i;
  logic [63:0] req_addr_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  rsp_valid_o;
  logic [1:0]  rsp_ready_i;
  logic [63:0] rsp_data_o;
  logic        rsp_last_o;
  logic        rsp_err_o;
  logic [31:0] axi_ar_addr_o;
  logic [3:0]  axi_ar_id_o;
  logic [7:0]  axi_ar_len_o;
  logic        axi_ar_valid_o;
  logic        axi_ar_ready_i;
  logic [63:0] axi_r_data_i;
  logic [3:0]  axi_r_id_i;
  logic [1:0]  axi_r_resp_i;
  logic        axi_r_last_i;
  logic        axi_r_valid_i;
  logic        axi_r_ready_o;
  logic        stray_r_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;
  beat_t sb_q0[$];
  beat_t sb_q1[$];

  typedef struct {
    logic [3:0] rid;
    logic       rvalid;
    logic [1:0] rdy;
    logic [1:0] resp;
    logic [1:0] e_vld;
    logic       e_rready;
    logic       e_stray;
  } vec_t;
  vec_t tbl[8];

  axi_rd_arbiter dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_addr_i     (req_addr_i),
    .req_ready_o    (req_ready_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_data_o     (rsp_data_o),
    .rsp_last_o     (rsp_last_o),
    .rsp_err_o      (rsp_err_o),
    .axi_ar_addr_o  (axi_ar_addr_o),
    .axi_ar_id_o    (axi_ar_id_o),
    .axi_ar_len_o   (axi_ar_len_o),
    .axi_ar_valid_o (axi_ar_valid_o),
    .axi_ar_ready_i (axi_ar_ready_i),
    .axi_r_data_i   (axi_r_data_i),
    .axi_r_id_i     (axi_r_id_i),
    .axi_r_resp_i   (axi_r_resp_i),
    .axi_r_last_i   (axi_r_last_i),
    .axi_r_valid_i  (axi_r_valid_i),
    .axi_r_ready_o  (axi_r_ready_o),
    .stray_r_o      (stray_r_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i    = 2'b00;
    req_addr_i     = '0;
    rsp_ready_i    = 2'b00;
    axi_ar_ready_i = 1'b0;
    axi_r_data_i   = '0;
    axi_r_id_i     = '0;
    axi_r_resp_i   = 2'b00;
    axi_r_last_i   = 1'b0;
    axi_r_valid_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni        = 1'b0;
    axi_r_valid_i = 1'b1;
    axi_r_id_i    = 4'd1;
    step();
    @(negedge clk_i);
    chk("rst_ar_valid", axi_ar_valid_o, 0);
    chk("rst_ar_addr", axi_ar_addr_o, 0);
    chk("rst_ar_id", axi_ar_id_o, 0);
    chk("rst_ar_len", axi_ar_len_o, 3);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_r_ready", axi_r_ready_o, 0);
    chk("rst_stray", stray_r_o, 0);
    idle_inputs();
    step();
    rst_ni = 1'b1;
  endtask

  // Compare any beat the DUT hands to a requester against the expected queue.
  task automatic sb_pop();
    beat_t b;
    for (int k = 0; k < 2; k++) begin
      if (rsp_valid_o[k] && rsp_ready_i[k]) begin
        if ((k == 0 ? sb_q0.size() : sb_q1.size()) == 0) begin
          chk($sformatf("sb_unexpected_beat%0d", k), 1, 0);
        end else begin
          b = (k == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
          chk($sformatf("sb_data%0d", k), rsp_data_o, b.data);
          chk($sformatf("sb_last%0d", k), rsp_last_o, b.last);
        end
      end
    end
  endtask

  task automatic ar_handshake(input logic [3:0] eid, input logic [31:0] eaddr);
    int n = 0;
    @(negedge clk_i);
    while (!axi_ar_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("ar_valid", axi_ar_valid_o, 1);
    chk("ar_id", axi_ar_id_o, eid);
    chk("ar_addr", axi_ar_addr_o, eaddr);
    chk("ar_len", axi_ar_len_o, 3);
    axi_ar_ready_i = 1'b1;
    step();
    axi_ar_ready_i = 1'b0;
  endtask

  task automatic send_beat(input logic [3:0] id, input logic [63:0] data, input logic last,
                           input bit owned, input bit rnd);
    bit hs = 0;
    axi_r_valid_i = 1'b1;
    axi_r_id_i    = id;
    axi_r_data_i  = data;
    axi_r_last_i  = last;
    axi_r_resp_i  = 2'b00;
    if (owned) begin
      if (id[0]) sb_q1.push_back('{data, last});
      else       sb_q0.push_back('{data, last});
    end
    for (int n = 0; n < 40 && !hs; n++) begin
      rsp_ready_i = (rnd && n < 8) ? 2'($urandom_range(0, 3)) : 2'b11;
      @(negedge clk_i);
      if (owned) begin
        chk("beat_rsp_valid", rsp_valid_o, 2'b01 << id[0]);
        chk("beat_r_ready", axi_r_ready_o, rsp_ready_i[id[0]]);
        chk("beat_stray", stray_r_o, 0);
      end else begin
        chk("drop_rsp_valid", rsp_valid_o, 0);
        chk("drop_r_ready", axi_r_ready_o, 1);
        chk("drop_stray", stray_r_o, 1);
      end
      sb_pop();
      hs = axi_r_ready_o;
      step();
    end
    if (!hs) chk("beat_handshake_timeout", 0, 1);
    axi_r_valid_i = 1'b0;
    axi_r_last_i  = 1'b0;
    rsp_ready_i   = 2'b00;
  endtask

  initial begin
    tbl[0] = '{4'd0, 1'b1, 2'b01, 2'b00, 2'b01, 1'b1, 1'b0};
    tbl[1] = '{4'd0, 1'b1, 2'b00, 2'b10, 2'b01, 1'b0, 1'b0};
    tbl[2] = '{4'd0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[3] = '{4'd0, 1'b1, 2'b10, 2'b11, 2'b01, 1'b0, 1'b0};
    tbl[4] = '{4'd1, 1'b1, 2'b11, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[5] = '{4'd1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[6] = '{4'd2, 1'b1, 2'b01, 2'b10, 2'b00, 1'b1, 1'b1};
    tbl[7] = '{4'd8, 1'b1, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1};

    // Single icache request with a stalled ARREADY
    do_reset();
    req_valid_i = 2'b01;
    req_addr_i  = 64'h0000_0000_0000_1000;
    @(negedge clk_i);
    chk("t1_req_ready", req_ready_o, 2'b01);
    step();
    req_valid_i = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("t1_stall_valid", axi_ar_valid_o, 1);
      chk("t1_stall_addr", axi_ar_addr_o, 32'h1000);
      chk("t1_stall_id", axi_ar_id_o, 0);
      step();
    end
    ar_handshake(4'd0, 32'h1000);
    @(negedge clk_i);
    chk("t1_ar_dropped", axi_ar_valid_o, 0);
    step();
    for (int b = 0; b < 4; b++) send_beat(4'd0, 64'hA000 + 64'(b), b == 3, 1, 0);
    chk("t1_busy_clear", dut.busy_q, 2'b00);

    // Round-robin pointer now favours dcache
    req_valid_i = 2'b11;
    req_addr_i  = {32'h3000, 32'h2000};
    @(negedge clk_i);
    chk("t2_rr_first", req_ready_o, 2'b10);
    step();
    req_valid_i = 2'b01;
    ar_handshake(4'd1, 32'h3000);
    @(negedge clk_i);
    chk("t2_rr_second", req_ready_o, 2'b01);
    step();
    req_valid_i = 2'b00;
    ar_handshake(4'd0, 32'h2000);

    // From reset with both requesting: icache first, dcache right after ARREADY
    do_reset();
    req_valid_i = 2'b11;
    req_addr_i  = {32'h3000, 32'h2000};
    @(negedge clk_i);
    chk("t3_first", req_ready_o, 2'b01);
    step();
    req_valid_i = 2'b10;
    @(negedge clk_i);
    chk("t3_no_grant_in_send", req_ready_o, 2'b00);
    chk("t3_ar_id0", axi_ar_id_o, 0);
    axi_ar_ready_i = 1'b1;
    step();
    axi_ar_ready_i = 1'b0;
    @(negedge clk_i);
    chk("t3_second", req_ready_o, 2'b10);
    step();
    req_valid_i = 2'b00;
    ar_handshake(4'd1, 32'h3000);

    // Interleaved R beats with random back-pressure
    for (int b = 0; b < 8; b++) begin
      send_beat((b % 2 == 0) ? 4'd1 : 4'd0, ((b % 2 == 0) ? 64'hD000 : 64'h1000) + 64'(b / 2),
                (b / 2) == 3, 1, 1);
      if (b == 6) chk("t4_dcache_busy_clear", dut.busy_q, 2'b01);
    end
    chk("t4_all_clear", dut.busy_q, 2'b00);
    chk("t4_sb_empty", 64'(sb_q0.size() + sb_q1.size()), 0);

    // Icache re-request while busy; dcache granted meanwhile
    req_valid_i = 2'b01;
    req_addr_i  = {32'h9000, 32'h8000};
    @(negedge clk_i);
    chk("t5_ic_grant", req_ready_o, 2'b01);
    step();
    ar_handshake(4'd0, 32'h8000);
    req_valid_i = 2'b11;
    @(negedge clk_i);
    chk("t5_dc_grant", req_ready_o, 2'b10);
    step();
    ar_handshake(4'd1, 32'h9000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      chk("t5_blocked", req_ready_o, 2'b00);
      step();
    end
    for (int b = 0; b < 3; b++) send_beat(4'd0, 64'h5000 + 64'(b), 0, 1, 0);
    axi_r_valid_i = 1'b1;
    axi_r_id_i    = 4'd0;
    axi_r_data_i  = 64'h5003;
    axi_r_last_i  = 1'b1;
    rsp_ready_i   = 2'b11;
    sb_q0.push_back('{64'h5003, 1'b1});
    @(negedge clk_i);
    chk("t5_no_grant_on_rlast", req_ready_o, 2'b00);
    sb_pop();
    step();
    idle_inputs();
    req_valid_i = 2'b11;
    req_addr_i  = {32'h9000, 32'h8000};
    @(negedge clk_i);
    chk("t5_grant_after_rlast", req_ready_o, 2'b01);
    step();
    req_valid_i = 2'b00;
    ar_handshake(4'd0, 32'h8000);

    // Routing vector table: icache burst open, dcache idle
    do_reset();
    req_valid_i = 2'b01;
    req_addr_i  = 64'h4000;
    step();
    req_valid_i = 2'b00;
    ar_handshake(4'd0, 32'h4000);
    for (int i = 0; i < 8; i++) begin
      axi_r_id_i    = tbl[i].rid;
      axi_r_valid_i = tbl[i].rvalid;
      rsp_ready_i   = tbl[i].rdy;
      axi_r_resp_i  = tbl[i].resp;
      axi_r_data_i  = 64'hC0DE_0000 + 64'(i);
      axi_r_last_i  = 1'b0;
      @(negedge clk_i);
      chk($sformatf("tbl%0d_rsp_valid", i), rsp_valid_o, tbl[i].e_vld & {2{tbl[i].rvalid}});
      chk($sformatf("tbl%0d_r_ready", i), axi_r_ready_o, tbl[i].e_rready);
      chk($sformatf("tbl%0d_stray", i), stray_r_o, tbl[i].e_stray);
      chk($sformatf("tbl%0d_data", i), rsp_data_o, 64'hC0DE_0000 + 64'(i));
      chk($sformatf("tbl%0d_err", i), rsp_err_o, tbl[i].resp[1]);
      step();
    end
    idle_inputs();

    // Reset asserted during beat 2 of a burst, with a dcache AR pending
    do_reset();
    req_valid_i = 2'b01;
    req_addr_i  = {32'h6000, 32'h5000};
    step();
    req_valid_i = 2'b00;
    ar_handshake(4'd0, 32'h5000);
    req_valid_i = 2'b10;
    @(negedge clk_i);
    chk("t6_dc_grant", req_ready_o, 2'b10);
    step();
    req_valid_i = 2'b00;
    send_beat(4'd0, 64'hE000, 0, 1, 0);
    axi_r_valid_i = 1'b1;
    axi_r_id_i    = 4'd0;
    axi_r_data_i  = 64'hE001;
    rsp_ready_i   = 2'b01;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_ar_valid_drop", axi_ar_valid_o, 0);
    chk("t6_busy_drop", dut.busy_q, 2'b00);
    chk("t6_rsp_valid_drop", rsp_valid_o, 0);
    chk("t6_r_ready_in_rst", axi_r_ready_o, 0);
    step();
    rst_ni = 1'b1;
    for (int b = 1; b < 4; b++) send_beat(4'd0, 64'hE000 + 64'(b), b == 3, 0, 0);
    req_valid_i = 2'b01;
    req_addr_i  = 64'h7000;
    @(negedge clk_i);
    chk("t6_regrant", req_ready_o, 2'b01);
    step();
    req_valid_i = 2'b00;
    ar_handshake(4'd0, 32'h7000);
    chk("final_sb_empty", 64'(sb_q0.size() + sb_q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
